// File: rtl/vx_wb_arbiter.sv
// Writeback arbiter: round-robin selection across execution-unit result streams with
// multi-beat packet locking, feeding one registered writeback beat per cycle.
module vx_wb_arbiter #(
    parameter int unsigned  NUM_INPUTS  = 4,
    parameter int unsigned  NUM_THREADS = 4,
    parameter int unsigned  XLEN        = 32,
    parameter int unsigned  NW_BITS     = 2,
    parameter int unsigned  NR_BITS     = 6,
    parameter int unsigned  UUID_WIDTH  = 44,
    localparam int unsigned DATAW = UUID_WIDTH + NW_BITS + NUM_THREADS + 32 + 1 + NR_BITS
                                    + NUM_THREADS * XLEN + 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_INPUTS-1:0]         in_valid,
    input  logic [NUM_INPUTS*DATAW-1:0]   in_data,
    output logic [NUM_INPUTS-1:0]         in_ready,
    output logic                          wb_valid,
    output logic [UUID_WIDTH-1:0]         wb_uuid,
    output logic [NW_BITS-1:0]            wb_wid,
    output logic [NUM_THREADS-1:0]        wb_tmask,
    output logic [31:0]                   wb_PC,
    output logic [NR_BITS-1:0]            wb_rd,
    output logic [NUM_THREADS*XLEN-1:0]   wb_data,
    output logic                          wb_sop,
    output logic                          wb_eop,
    output logic [31:0]                   perf_stalls
);

    localparam int unsigned IDX_W     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int unsigned LANEW     = NUM_THREADS * XLEN;
    localparam int unsigned EOP_POS   = 0;
    localparam int unsigned SOP_POS   = 1;
    localparam int unsigned DATA_LSB  = 2;
    localparam int unsigned RD_LSB    = DATA_LSB + LANEW;
    localparam int unsigned WB_POS    = RD_LSB + NR_BITS;
    localparam int unsigned PC_LSB    = WB_POS + 1;
    localparam int unsigned TMASK_LSB = PC_LSB + 32;
    localparam int unsigned WID_LSB   = TMASK_LSB + NUM_THREADS;
    localparam int unsigned UUID_LSB  = WID_LSB + NW_BITS;

    logic                    lock_q,       lock_d;
    logic [IDX_W-1:0]        lock_idx_q,   lock_idx_d;
    logic [NW_BITS-1:0]      lock_wid_q,   lock_wid_d;
    logic [IDX_W-1:0]        last_grant_q, last_grant_d;
    logic                    wb_valid_q,   wb_valid_d;
    logic [UUID_WIDTH-1:0]   wb_uuid_q,    wb_uuid_d;
    logic [NW_BITS-1:0]      wb_wid_q,     wb_wid_d;
    logic [NUM_THREADS-1:0]  wb_tmask_q,   wb_tmask_d;
    logic [31:0]             wb_pc_q,      wb_pc_d;
    logic [NR_BITS-1:0]      wb_rd_q,      wb_rd_d;
    logic [LANEW-1:0]        wb_data_q,    wb_data_d;
    logic                    wb_sop_q,     wb_sop_d;
    logic                    wb_eop_q,     wb_eop_d;
    logic [31:0]             perf_q,       perf_d;

    logic [NUM_INPUTS-1:0]   grant_c;
    logic [IDX_W-1:0]        grant_idx_c;
    logic                    accept_c;
    logic                    found_c;
    int unsigned             idx_c;
    logic [DATAW-1:0]        sel_beat_c;
    logic                    stall_c;

    // Grant: locked stream only, otherwise first valid input from last_grant+1 with wrap
    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        found_c     = 1'b0;
        idx_c       = 0;
        if (lock_q) begin
            if (in_valid[lock_idx_q]) begin
                grant_c[lock_idx_q] = 1'b1;
                grant_idx_c         = lock_idx_q;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
                idx_c = (32'(last_grant_q) + 32'd1 + k) % NUM_INPUTS;
                if (!found_c && in_valid[idx_c]) begin
                    found_c        = 1'b1;
                    grant_c[idx_c] = 1'b1;
                    grant_idx_c    = IDX_W'(idx_c);
                end
            end
        end
        if (reset) begin
            grant_c     = '0;
            grant_idx_c = '0;
        end
    end

    assign accept_c   = |grant_c;
    assign sel_beat_c = in_data[32'(grant_idx_c) * DATAW +: DATAW];
    assign stall_c    = |(in_valid & ~grant_c);

    // Next-state: lock tracking, RR pointer, writeback register load, stall counter
    always_comb begin
        lock_d       = lock_q;
        lock_idx_d   = lock_idx_q;
        lock_wid_d   = lock_wid_q;
        last_grant_d = last_grant_q;
        wb_valid_d   = 1'b0;
        wb_uuid_d    = wb_uuid_q;
        wb_wid_d     = wb_wid_q;
        wb_tmask_d   = wb_tmask_q;
        wb_pc_d      = wb_pc_q;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        wb_sop_d     = wb_sop_q;
        wb_eop_d     = wb_eop_q;
        perf_d       = perf_q + 32'(stall_c);
        if (accept_c) begin
            last_grant_d = grant_idx_c;
            if (sel_beat_c[EOP_POS]) begin
                lock_d = 1'b0;
            end else begin
                lock_d     = 1'b1;
                lock_idx_d = grant_idx_c;
                lock_wid_d = sel_beat_c[WID_LSB +: NW_BITS];
            end
            if (sel_beat_c[WB_POS]) begin
                wb_valid_d = 1'b1;
                wb_uuid_d  = sel_beat_c[UUID_LSB +: UUID_WIDTH];
                wb_wid_d   = sel_beat_c[WID_LSB +: NW_BITS];
                wb_tmask_d = sel_beat_c[TMASK_LSB +: NUM_THREADS];
                wb_pc_d    = sel_beat_c[PC_LSB +: 32];
                wb_rd_d    = sel_beat_c[RD_LSB +: NR_BITS];
                wb_data_d  = sel_beat_c[DATA_LSB +: LANEW];
                wb_sop_d   = sel_beat_c[SOP_POS];
                wb_eop_d   = sel_beat_c[EOP_POS];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q       <= 1'b0;
            lock_idx_q   <= '0;
            lock_wid_q   <= '0;
            last_grant_q <= IDX_W'(NUM_INPUTS - 1);
            wb_valid_q   <= 1'b0;
            wb_uuid_q    <= '0;
            wb_wid_q     <= '0;
            wb_tmask_q   <= '0;
            wb_pc_q      <= '0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            wb_sop_q     <= 1'b0;
            wb_eop_q     <= 1'b0;
            perf_q       <= '0;
        end else begin
            lock_q       <= lock_d;
            lock_idx_q   <= lock_idx_d;
            lock_wid_q   <= lock_wid_d;
            last_grant_q <= last_grant_d;
            wb_valid_q   <= wb_valid_d;
            wb_uuid_q    <= wb_uuid_d;
            wb_wid_q     <= wb_wid_d;
            wb_tmask_q   <= wb_tmask_d;
            wb_pc_q      <= wb_pc_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            wb_sop_q     <= wb_sop_d;
            wb_eop_q     <= wb_eop_d;
            perf_q       <= perf_d;
        end
    end

    // A locked packet must keep the warp id it started with
    always_ff @(posedge clk) begin
        if (!reset && lock_q && accept_c) begin
            assert (sel_beat_c[WID_LSB +: NW_BITS] == lock_wid_q);
        end
    end

    assign in_ready    = grant_c;
    assign wb_valid    = wb_valid_q;
    assign wb_uuid     = wb_uuid_q;
    assign wb_wid      = wb_wid_q;
    assign wb_tmask    = wb_tmask_q;
    assign wb_PC       = wb_pc_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign wb_sop      = wb_sop_q;
    assign wb_eop      = wb_eop_q;
    assign perf_stalls = perf_q;

endmodule

// File: tb/tb_vx_wb_arbiter.sv
// Directed bench for vx_wb_arbiter: RR order, packet locking, lock bubbles,
// wb=0 consumption and reset mid-packet.
module tb_vx_wb_arbiter;

    localparam int DW = 219;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      in_valid;
    logic [4*DW-1:0] in_data;
    logic [3:0]      in_ready;
    logic            wb_valid;
    logic [43:0]     wb_uuid;
    logic [1:0]      wb_wid;
    logic [3:0]      wb_tmask;
    logic [31:0]     wb_PC;
    logic [5:0]      wb_rd;
    logic [127:0]    wb_data;
    logic            wb_sop;
    logic            wb_eop;
    logic [31:0]     perf_stalls;

    int checks = 0;
    int errors = 0;

    vx_wb_arbiter dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .wb_valid(wb_valid), .wb_uuid(wb_uuid), .wb_wid(wb_wid), .wb_tmask(wb_tmask),
        .wb_PC(wb_PC), .wb_rd(wb_rd), .wb_data(wb_data), .wb_sop(wb_sop), .wb_eop(wb_eop),
        .perf_stalls(perf_stalls)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mk(input logic [43:0] uuid, input logic [1:0] wid,
                                         input logic [3:0] tmask, input logic [31:0] pc,
                                         input logic wb, input logic [5:0] rd,
                                         input logic [127:0] data, input logic sop,
                                         input logic eop);
        return {uuid, wid, tmask, pc, wb, rd, data, sop, eop};
    endfunction

    function automatic logic [DW-1:0] single(input int i, input logic [5:0] rd);
        return mk(44'(100 + i), 2'(i), 4'hF, 32'h1000 + 32'(i), 1'b1, rd,
                  {4{32'(rd) * 32'h01010101}}, 1'b1, 1'b1);
    endfunction

    task automatic set_slot(input int i, input logic [DW-1:0] b);
        in_data[i*DW +: DW] = b;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 4'hF;
        in_data  = '0;

        // Reset and idle
        #1;
        chk("rst_ready", 128'(in_ready), 128'h0);
        tick();
        in_valid = 4'h0;
        tick();
        chk("rst_wb_valid", 128'(wb_valid), 128'h0);
        chk("rst_perf", 128'(perf_stalls), 128'h0);
        chk("rst_rd", 128'(wb_rd), 128'h0);
        chk("rst_data", wb_data, 128'h0);
        reset = 1'b0;
        repeat (10) tick();
        chk("idle_perf", 128'(perf_stalls), 128'h0);
        chk("idle_ready", 128'(in_ready), 128'h0);
        chk("idle_wb_valid", 128'(wb_valid), 128'h0);

        // All four single-beat contenders: order 0,1,2,3,0,1,2,3
        for (int i = 0; i < 4; i++) set_slot(i, single(i, 6'(i + 1)));
        in_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("rr_ready", 128'(in_ready), 128'(4'b0001 << (c % 4)));
            tick();
            chk("rr_wb_valid", 128'(wb_valid), 128'h1);
            chk("rr_rd", 128'(wb_rd), 128'(c % 4 + 1));
            if (c == 0) begin
                chk("rr_uuid", 128'(wb_uuid), 128'd100);
                chk("rr_wid", 128'(wb_wid), 128'h0);
                chk("rr_tmask", 128'(wb_tmask), 128'hF);
                chk("rr_pc", 128'(wb_PC), 128'h1000);
                chk("rr_data", wb_data, 128'h01010101_01010101_01010101_01010101);
                chk("rr_sop_eop", 128'({wb_sop, wb_eop}), 128'h3);
            end
        end
        chk("rr_perf", 128'(perf_stalls), 128'd8);
        in_valid = 4'h0;

        // Three-beat packet from input 2 stays contiguous against input 0
        set_slot(2, mk(44'd200, 2'd2, 4'h3, 32'h2000, 1'b1, 6'd10, 128'h10, 1'b1, 1'b0));
        in_valid = 4'b0101;
        #1; chk("pk_a_ready", 128'(in_ready), 128'b0001);
        tick(); chk("pk_a_rd", 128'(wb_rd), 128'd1);
        #1; chk("pk_b_ready", 128'(in_ready), 128'b0100);
        tick(); chk("pk_b_rd", 128'(wb_rd), 128'd10);
        chk("pk_b_sop_eop", 128'({wb_sop, wb_eop}), 128'b10);
        set_slot(2, mk(44'd200, 2'd2, 4'h3, 32'h2000, 1'b1, 6'd11, 128'h11, 1'b0, 1'b0));
        #1; chk("pk_c_ready", 128'(in_ready), 128'b0100);
        tick(); chk("pk_c_rd", 128'(wb_rd), 128'd11);
        set_slot(2, mk(44'd200, 2'd2, 4'h3, 32'h2000, 1'b1, 6'd12, 128'h12, 1'b0, 1'b1));
        #1; chk("pk_d_ready", 128'(in_ready), 128'b0100);
        tick(); chk("pk_d_rd", 128'(wb_rd), 128'd12);
        chk("pk_d_sop_eop", 128'({wb_sop, wb_eop}), 128'b01);
        in_valid = 4'b0001;
        #1; chk("pk_e_ready", 128'(in_ready), 128'b0001);
        tick(); chk("pk_e_rd", 128'(wb_rd), 128'd1);
        chk("pk_perf", 128'(perf_stalls), 128'd12);
        in_valid = 4'h0;

        // Lock hold: input 1 idles mid-packet, input 3 must wait
        set_slot(1, mk(44'd300, 2'd1, 4'hF, 32'h3000, 1'b1, 6'd20, 128'h20, 1'b1, 1'b0));
        set_slot(3, single(3, 6'd4));
        in_valid = 4'b1010;
        #1; chk("lk_f_ready", 128'(in_ready), 128'b0010);
        tick(); chk("lk_f_rd", 128'(wb_rd), 128'd20);
        in_valid = 4'b1000;
        for (int c = 0; c < 2; c++) begin
            #1; chk("lk_bubble_ready", 128'(in_ready), 128'h0);
            tick(); chk("lk_bubble_wb_valid", 128'(wb_valid), 128'h0);
        end
        set_slot(1, mk(44'd300, 2'd1, 4'hF, 32'h3000, 1'b1, 6'd21, 128'h21, 1'b0, 1'b1));
        in_valid = 4'b1010;
        #1; chk("lk_i_ready", 128'(in_ready), 128'b0010);
        tick(); chk("lk_i_rd", 128'(wb_rd), 128'd21);
        in_valid = 4'b1000;
        #1; chk("lk_j_ready", 128'(in_ready), 128'b1000);
        tick(); chk("lk_j_rd", 128'(wb_rd), 128'd4);
        chk("lk_perf", 128'(perf_stalls), 128'd16);
        in_valid = 4'h0;

        // wb=0 beat is consumed but leaves the writeback register untouched
        set_slot(0, mk(44'd400, 2'd0, 4'hF, 32'h4000, 1'b0, 6'd33, 128'hDEAD, 1'b1, 1'b1));
        in_valid = 4'b0001;
        #1; chk("nowb_ready", 128'(in_ready), 128'b0001);
        tick();
        chk("nowb_wb_valid", 128'(wb_valid), 128'h0);
        chk("nowb_data", wb_data, 128'h04040404_04040404_04040404_04040404);
        chk("nowb_rd", 128'(wb_rd), 128'd4);
        in_valid = 4'h0;

        // Reset right after input 2 opens a packet clears lock and pointer
        set_slot(2, mk(44'd500, 2'd2, 4'hF, 32'h5000, 1'b1, 6'd40, 128'h40, 1'b1, 1'b0));
        in_valid = 4'b0100;
        #1; chk("rm_sop_ready", 128'(in_ready), 128'b0100);
        tick(); chk("rm_sop_rd", 128'(wb_rd), 128'd40);
        set_slot(0, single(0, 6'd1));
        in_valid = 4'b0101;
        reset    = 1'b1;
        #1; chk("rm_rst_ready", 128'(in_ready), 128'h0);
        tick();
        chk("rm_rst_wb_valid", 128'(wb_valid), 128'h0);
        chk("rm_rst_rd", 128'(wb_rd), 128'h0);
        chk("rm_rst_perf", 128'(perf_stalls), 128'h0);
        reset = 1'b0;
        #1; chk("rm_ready", 128'(in_ready), 128'b0001);
        tick();
        chk("rm_wb_valid", 128'(wb_valid), 128'h1);
        chk("rm_rd", 128'(wb_rd), 128'd1);
        chk("rm_perf", 128'(perf_stalls), 128'd1);
        in_valid = 4'h0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
